// File: rtl/branch_comparator.sv
// Execute-stage branch condition evaluator: registered, enable-masked taken result.
// Optional BRANCH_CMP_STATS_EN adds eval_count / taken_count statistics outputs.
module branch_comparator #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              enable,
  input  logic [2:0]        operation,
  output logic              result_masked,
  output logic              result_valid
`ifdef BRANCH_CMP_STATS_EN
  ,
  output logic [31:0]       eval_count,
  output logic [31:0]       taken_count
`endif
);

  localparam int unsigned MSB   = DATA_W - 1;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } e_branch_operation_sel;

  typedef enum logic {
    BRANCH_NOT_TAKEN = 1'b0,
    BRANCH_TAKEN     = 1'b1
  } e_branch_result;

  logic eq;
  logic lt_u;
  logic lt_s;
  logic condition;
  logic taken_next;

  // Signed compare decided by sign bits when they differ, else by magnitude.
  always_comb begin
    eq   = (rs1_data == rs2_data);
    lt_u = (rs1_data < rs2_data);
    lt_s = (rs1_data[MSB] != rs2_data[MSB]) ? rs1_data[MSB] : lt_u;
  end

  // Reserved encodings 010/011 evaluate as not taken.
  always_comb begin
    condition = 1'b0;
    case (operation)
      CMP_BEQ:  condition = eq;
      CMP_BNE:  condition = ~eq;
      CMP_BLT:  condition = lt_s;
      CMP_BGE:  condition = ~lt_s;
      CMP_BLTU: condition = lt_u;
      CMP_BGEU: condition = ~lt_u;
      default:  condition = 1'b0;
    endcase
    taken_next = condition & enable;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_masked <= BRANCH_NOT_TAKEN;
      result_valid  <= 1'b0;
    end else begin
      result_masked <= taken_next ? BRANCH_TAKEN : BRANCH_NOT_TAKEN;
      result_valid  <= enable;
    end
  end

`ifdef BRANCH_CMP_STATS_EN
  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else begin
      if (enable)     eval_count  <= eval_count + CNT_W'(1);
      if (taken_next) taken_count <= taken_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_comparator.sv
// Scoreboard bench for branch_comparator: directed boundary cases plus random traffic.
module tb_branch_comparator;

  localparam int unsigned DATA_W = 32;
  localparam int          LIMIT  = 20000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              enable;
  logic [2:0]        operation;
  logic              result_masked;
  logic              result_valid;
`ifdef BRANCH_CMP_STATS_EN
  logic [31:0]       eval_count;
  logic [31:0]       taken_count;
`endif

  branch_comparator #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .enable        (enable),
    .operation     (operation),
    .result_masked (result_masked),
    .result_valid  (result_valid)
`ifdef BRANCH_CMP_STATS_EN
    ,
    .eval_count    (eval_count),
    .taken_count   (taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    int          due;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int          cycles = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          done   = 1'b0;
  logic [31:0] eval_m  = '0;
  logic [31:0] taken_m = '0;

  // Branch rule straight from the ISA definition.
  function automatic logic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic en, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic t;
    @(negedge clk);
    rst_n = rst; enable = en; operation = op; rs1_data = a; rs2_data = b;
    t = (en === 1'b1) ? model(op, a, b) : 1'b0;
    if (rst !== 1'b1) begin
      eval_m  = '0;
      taken_m = '0;
    end else if (en === 1'b1) begin
      e.taken = t; e.due = cycles + 1; e.op = op; e.a = a; e.b = b;
      exp_q.push_back(e);
      eval_m = eval_m + 32'd1;
      if (t) taken_m = taken_m + 32'd1;
    end
  endtask

  task automatic all_ops(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] ops[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    foreach (ops[i]) drive(1'b1, 1'b1, ops[i], a, b);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles > LIMIT) begin
        checks++; errors++;
        $display("FAIL timeout: cycles=%0d limit=%0d", cycles, LIMIT);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (mon_en) begin
        if (result_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got valid=1 taken=%b, required no result", result_masked);
          end else begin
            e = exp_q.pop_front();
            if (e.due != cycles || result_masked !== e.taken) begin
              errors++;
              $display("FAIL result op=%b a=%h b=%h: got taken=%b at cycle %0d, required taken=%b at cycle %0d",
                       e.op, e.a, e.b, result_masked, cycles, e.taken, e.due);
            end
          end
        end else if (result_valid === 1'b0) begin
          checks++;
          if (result_masked !== 1'b0) begin
            errors++;
            $display("FAIL idle_masked: got taken=%b with valid=0, required 0", result_masked);
          end
        end else begin
          checks++; errors++;
          $display("FAIL valid_unknown: got valid=%b, required 0 or 1", result_valid);
        end
`ifdef BRANCH_CMP_STATS_EN
        checks++;
        if (eval_count !== eval_m || taken_count !== taken_m) begin
          errors++;
          $display("FAIL stats: got eval=%0d taken=%0d, required eval=%0d taken=%0d",
                   eval_count, taken_count, eval_m, taken_m);
        end
`endif
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_results: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n = 1'b0; enable = 1'b0; operation = 3'b000; rs1_data = '0; rs2_data = '0;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    all_ops(32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    all_ops(32'hFFFF_FFCE, 32'hFFFF_FFCD);
    all_ops(32'hFFFF_FFCE, 32'd51);
    all_ops(32'h8000_0000, 32'h7FFF_FFFF);
    drive(1'b1, 1'b1, 3'b100, 32'h8000_0000, 32'h8000_0001);
    drive(1'b1, 1'b1, 3'b101, 32'h8000_0000, 32'h8000_0001);
    drive(1'b1, 1'b1, 3'b100, 32'h8000_0000, 32'h0000_0001);
    drive(1'b1, 1'b1, 3'b101, 32'h8000_0000, 32'h0000_0001);
    drive(1'b1, 1'b1, 3'b100, 32'h0000_0000, 32'h8000_0000);
    drive(1'b1, 1'b1, 3'b101, 32'h0000_0000, 32'h8000_0000);
    drive(1'b1, 1'b1, 3'b100, 32'h0000_0000, 32'h0000_0001);
    drive(1'b1, 1'b1, 3'b101, 32'h0000_0000, 32'h0000_0001);

    drive(1'b1, 1'b0, 3'b000, 32'd5, 32'd5);
    drive(1'b1, 1'b0, 3'bxxx, 32'd5, 32'd5);
    drive(1'b0, 1'b1, 3'b000, 32'd5, 32'd5);
    drive(1'b1, 1'b1, 3'b010, 32'd5, 32'd5);
    drive(1'b1, 1'b1, 3'b011, 32'd7, 32'd9);

    for (int i = 0; i < 2000; i++) begin
      a = pick();
      b = ($urandom % 4 == 0) ? a : pick();
      drive(($urandom % 50) != 0, ($urandom % 4) != 0, 3'($urandom), a, b);
    end

    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    done = 1'b1;
  end

endmodule

// File: doc/branch_comparator.md
Name: branch_comparator

Overview:
- Execute-stage branch condition evaluator for the RV32I core.
- Compares rs1/rs2 operands per the decoded branch operation and returns a registered, enable-masked taken/not-taken result to fetch/PC-select logic.
- Covers all six RV32I conditional branches, signed and unsigned.

Parameters:
- DATA_W, default instructions_pkg::XLEN (32): operand width in bits; must be ≥2.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- rs1_data  input  DATA_W  first source operand.
- rs2_data  input  DATA_W  second source operand.
- enable  input  1  branch evaluation request; high means the instruction in execute is a conditional branch.
- operation  input  3  control_pkg::e_branch_operation_sel, encoded as funct3: CMP_BEQ=000, CMP_BNE=001, CMP_BLT=100, CMP_BGE=101, CMP_BLTU=110, CMP_BGEU=111.
- result_masked  output  1  control_pkg::e_branch_result: BRANCH_NOT_TAKEN=0, BRANCH_TAKEN=1.
- result_valid  output  1  high for one cycle after a cycle in which enable was high.

Behaviour:
- Compare terms, combinational from current inputs:
  - eq = (rs1 == rs2).
  - lt_s = signed(rs1) < signed(rs2), two's complement, MSB is sign.
  - lt_u = unsigned(rs1) < unsigned(rs2).
- Condition per operation:
  - BEQ = eq; BNE = !eq.
  - BLT = lt_s; BGE = !lt_s.
  - BLTU = lt_u; BGEU = !lt_u.
  - Encodings 010 and 011 are illegal → condition 0 (not taken). No error signalled.
- Masking: taken_next = condition & enable. enable=0 always gives NOT_TAKEN regardless of operands or operation.
- Register stage: result_masked <= taken_next; result_valid <= enable.
- Latency is exactly 1 clock. Inputs sampled at edge N appear on outputs after edge N. Back-to-back enables allowed every cycle, no stall or handshake.
- Reset: when rst_n=0 at a rising edge, result_masked=NOT_TAKEN(0) and result_valid=0. Reset overrides a simultaneous enable. The first evaluation after reset is the one sampled at the first edge with rst_n=1.
- Boundary values:
  - 0x80000000 vs 0x7FFFFFFF: signed less-than, unsigned greater-than.
  - Equal operands: BGE/BGEU taken, BLT/BLTU not taken.
  - No overflow from subtraction. Implement the signed compare as sign-aware, not as a truncated difference.
- X/undefined operation while enable=0 must not propagate: output is 0.

Optional Feature:
- Macro: BRANCH_CMP_STATS_EN.
- When defined, two extra outputs are added:
  - eval_count[31:0]: increments on each edge with enable=1.
  - taken_count[31:0]: increments on each edge with taken_next=1.
- Both counters clear to 0 on synchronous reset and wrap modulo 2^32.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Equal zero operands: rs1=0, rs2=0, enable=1 for each op in turn → BEQ/BGE/BGEU taken; BNE/BLT/BLTU not taken; valid=1 one cycle later.
- rs1=-50 (0xFFFFFFCE), rs2=-51 (0xFFFFFFCD) → BNE, BGE, BGEU taken; BEQ, BLT, BLTU not taken.
- rs1=-50, rs2=51 → BNE, BLT, BGEU taken; BEQ, BLTU, BGE not taken.
- Sign boundaries, BLT then BGE:
  - 0x80000000 vs 0x80000001 → BLT taken, BGE not.
  - 0x80000000 vs 0x00000001 → BLT taken, BGE not.
  - 0x00000000 vs 0x80000000 → BLT not taken, BGE taken.
  - 0x00000000 vs 0x00000001 → BLT taken, BGE not.
- Masking and reset:
  - BEQ 5 vs 5 with enable=0 → result 0, valid 0.
  - Assert rst_n=0 in the same cycle as enable=1 (BEQ equal) → outputs 0 after the edge.
  - Illegal op 010 with enable=1 → not taken, valid=1.
- With BRANCH_CMP_STATS_EN defined: the 6 zero-operand ops give eval_count=6, taken_count=3; reset returns both to 0.
